pulse_gen: RTL and testbench

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen.sv | 132 +++++++++++++
 tb/tb_pulse_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: high/low phase lengths, finite or continuous count.
// Optional output polarity inversion with macro PULSE_GEN_POL_INV_EN.
module pulse_gen #(
    parameter int CNT_W = 16
) (
    input  logic             mclk,
    input  logic             mreset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [7:0]       pulse_num,
`ifdef PULSE_GEN_POL_INV_EN
    input  logic             pol_inv,
`endif
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pulse_cnt
);

    typedef enum logic [3:0] {
        IDLE = 4'd1,
        HIGH = 4'd2,
        LOW  = 4'd3,
        DONE = 4'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] high_q, high_n;
    logic [CNT_W-1:0] low_q, low_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       num_q, num_n;
    logic [7:0]       pcnt_n, pcnt_inc;
    logic             pol_q, pol_n, pol_in;
    logic [CNT_W-1:0] high_in, low_in;

`ifdef PULSE_GEN_POL_INV_EN
    assign pol_in = pol_inv;
`else
    assign pol_in = 1'b0;
`endif

    // zero-length phases behave as one cycle
    assign high_in  = (high_len == '0) ? ONE : high_len;
    assign low_in   = (low_len == '0) ? ONE : low_len;
    assign pcnt_inc = pulse_cnt + 8'd1;

    always_comb begin
        state_n = state;
        high_n  = high_q;
        low_n   = low_q;
        num_n   = num_q;
        cnt_n   = cnt;
        pcnt_n  = pulse_cnt;
        pol_n   = pol_q;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n = HIGH;
                    high_n  = high_in;
                    low_n   = low_in;
                    num_n   = pulse_num;
                    pcnt_n  = 8'd0;
                    cnt_n   = high_in - ONE;
                    pol_n   = pol_in;
                end
            end
            HIGH: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n = LOW;
                    cnt_n   = low_q - ONE;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            LOW: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    pcnt_n = pcnt_inc;
                    if (num_q != 8'd0 && pcnt_inc == num_q) begin
                        state_n = DONE;
                    end else begin
                        state_n = HIGH;
                        cnt_n   = high_q - ONE;
                    end
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge mreset_n) begin
        if (!mreset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge mclk or negedge mreset_n) begin
        if (!mreset_n) begin
            high_q    <= '0;
            low_q     <= '0;
            num_q     <= 8'd0;
            cnt       <= '0;
            pulse_cnt <= 8'd0;
            pol_q     <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            high_q    <= high_n;
            low_q     <= low_n;
            num_q     <= num_n;
            cnt       <= cnt_n;
            pulse_cnt <= pcnt_n;
            pol_q     <= pol_n;
            pulse_out <= (state_n == HIGH) ^ pol_n;
        end
    end

    assign busy = (state == HIGH) || (state == LOW);
    assign done = (state == DONE);

endmodule

// File: tb/tb_pulse_gen.sv
// Directed scoreboard bench for pulse_gen (default build, no polarity option).
module tb_pulse_gen;

    logic        mclk = 1'b0;
    logic        mreset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] high_len = '0;
    logic [15:0] low_len = '0;
    logic [7:0]  pulse_num = '0;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic [7:0]  pulse_cnt;

    int checks = 0;
    int failures = 0;
    string tag = "init";
    logic [10:0] sb[$];

    pulse_gen #(.CNT_W(16)) dut (
        .mclk(mclk),
        .mreset_n(mreset_n),
        .start(start),
        .stop(stop),
        .high_len(high_len),
        .low_len(low_len),
        .pulse_num(pulse_num),
        .pulse_out(pulse_out),
        .busy(busy),
        .done(done),
        .pulse_cnt(pulse_cnt)
    );

    always #5 mclk = ~mclk;

    function automatic logic [10:0] obs();
        return {pulse_out, busy, done, pulse_cnt};
    endfunction

    task automatic chk(input string t, input logic [10:0] o, input logic [10:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic tick();
        logic [10:0] e;
        @(posedge mclk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs());
        end else begin
            e = sb.pop_front();
            chk(tag, obs(), e);
        end
    endtask

    task automatic expect_n(input int n, input bit po, input bit b, input bit d,
                            input logic [7:0] c);
        for (int i = 0; i < n; i++) begin
            sb.push_back({po, b, d, c});
            tick();
            start = 1'b0;
            stop  = 1'b0;
        end
    endtask

    task automatic launch(input logic [15:0] h, input logic [15:0] l, input logic [7:0] n);
        high_len  = h;
        low_len   = l;
        pulse_num = n;
        start     = 1'b1;
    endtask

    task automatic run_029();
        launch(16'd3, 16'd2, 8'd2);
        expect_n(3, 1, 1, 0, 8'd0);
        expect_n(2, 0, 1, 0, 8'd0);
        expect_n(3, 1, 1, 0, 8'd1);
        expect_n(2, 0, 1, 0, 8'd1);
        expect_n(1, 0, 0, 1, 8'd2);
        expect_n(1, 0, 0, 0, 8'd2);
    endtask

    initial begin
        #3;
        tag = "reset";
        chk(tag, obs(), 11'h000);
        @(posedge mclk);
        #3;
        mreset_n = 1'b1;
        @(posedge mclk);
        #1;
        chk("idle_after_reset", obs(), 11'h000);

        tag = "basic_3_2_2";
        run_029();

        tag = "zero_len";
        launch(16'd0, 16'd0, 8'd1);
        expect_n(1, 1, 1, 0, 8'd0);
        expect_n(1, 0, 1, 0, 8'd0);
        expect_n(1, 0, 0, 1, 8'd1);
        expect_n(1, 0, 0, 0, 8'd1);

        tag = "start_and_stop";
        start = 1'b1;
        stop  = 1'b1;
        expect_n(2, 0, 0, 0, 8'd1);

        tag = "start_in_high";
        launch(16'd2, 16'd1, 8'd1);
        sb.push_back({1'b1, 1'b1, 1'b0, 8'd0});
        tick();
        start     = 1'b1;
        high_len  = 16'd7;
        pulse_num = 8'd0;
        expect_n(1, 1, 1, 0, 8'd0);
        expect_n(1, 0, 1, 0, 8'd0);
        expect_n(1, 0, 0, 1, 8'd1);
        expect_n(1, 0, 0, 0, 8'd1);

        tag = "continuous";
        launch(16'd1, 16'd1, 8'd0);
        for (int k = 1; k <= 600; k++) begin
            sb.push_back({(k % 2 == 1), 1'b1, 1'b0, 8'(((k - 1) / 2) % 256)});
            tick();
            start = 1'b0;
        end
        stop = 1'b1;
        tag = "after_stop";
        expect_n(3, 0, 0, 0, 8'(299 % 256));

        tag = "stop_in_high";
        launch(16'd4, 16'd1, 8'd5);
        expect_n(2, 1, 1, 0, 8'd0);
        stop = 1'b1;
        expect_n(2, 0, 0, 0, 8'd0);

        tag = "reset_mid_low";
        launch(16'd2, 16'd4, 8'd3);
        expect_n(2, 1, 1, 0, 8'd0);
        expect_n(1, 0, 1, 0, 8'd0);
        mreset_n = 1'b0;
        #2;
        chk("async_reset", obs(), 11'h000);
        mreset_n = 1'b1;
        tag = "idle_post_reset";
        expect_n(2, 0, 0, 0, 8'd0);

        tag = "clean_retrain";
        run_029();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
